eth_fcs_check_sched_64: RTL and testbench
=========================================

Name: eth_fcs_check_sched_64

Overview:
Frame-granular round-robin scheduler that shares one 64-bit Ethernet FCS checker among PORTS AXI-Stream sources.
- Selects one source per frame and holds the grant until that source's tlast handshake.
- Tags the forwarded frame with the source index.
- Tracks in-flight frames so checker results (done/bad pulses) are attributed to the correct port.
- Sits between the per-port receive MAC paths and the shared FCS checker instance.

Parameters:
PORTS, 4, number of source ports (2..16)
ID_WIDTH, $clog2(PORTS), width of port tag
INFLIGHT_DEPTH, 4, frames allowed between frame start and checker result (power of 2, >=2)
CNT_WIDTH, 16, width of per-port bad-FCS counters

Ports:
clk  in  1  clock, all logic on rising edge
rst_n  in  1  asynchronous active-low reset
s_axis_tdata  in  PORTS*64  per-port data, port i at [i*64+:64]
s_axis_tkeep  in  PORTS*8  per-port byte enables
s_axis_tvalid  in  PORTS  per-port valid
s_axis_tready  out  PORTS  per-port ready
s_axis_tlast  in  PORTS  per-port end of frame
s_axis_tuser  in  PORTS  per-port error flag
m_axis_tdata  out  64  to checker
m_axis_tkeep  out  8  to checker
m_axis_tvalid  out  1  to checker
m_axis_tready  in  1  from checker
m_axis_tlast  out  1  to checker
m_axis_tuser  out  1  to checker
m_axis_tid  out  ID_WIDTH  granted port index
chk_frame_done  in  1  one-cycle pulse per frame leaving the checker (output tlast handshake)
chk_bad_fcs  in  1  coincident with chk_frame_done, 1 = FCS bad
status_bad_fcs_count  out  PORTS*CNT_WIDTH  per-port saturating bad-FCS counters
status_frame_err  out  1  sticky; done pulse received with no frame in flight
busy  out  1  grant held (state XFER)

Behaviour:
- Reset (rst_n low, async):
  - state IDLE; last_grant = PORTS-1, so port 0 has first priority.
  - s_axis_tready all 0, m_axis_tvalid 0, m_axis_tid 0, busy 0.
  - Counters 0, in-flight FIFO empty, status_frame_err 0.
  - A frame in progress when reset asserts is abandoned; the bench must not expect its remainder.
- State IDLE:
  - Requesters = s_axis_tvalid bits.
  - Pick the first set bit scanning last_grant+1 .. last_grant+PORTS, modulo PORTS.
  - A grant is made only when at least one requester is set and the in-flight FIFO is not full.
  - On grant: register grant_reg, push the index into the FIFO, go to XFER next cycle. This is one bubble cycle per frame.
  - In IDLE, m_axis_tvalid is 0 and all s_axis_tready are 0.
- State XFER: combinational pass-through, zero latency.
  - m_axis_{tdata,tkeep,tvalid,tlast,tuser} = port grant_reg signals.
  - s_axis_tready[grant_reg] = m_axis_tready; all other tready bits are 0.
  - m_axis_tid = grant_reg and is stable for the whole frame.
  - On m_axis_tvalid & m_axis_tready & m_axis_tlast: last_grant = grant_reg, go to IDLE.
  - A single-beat frame goes IDLE -> XFER -> IDLE.
- busy = (state == XFER).
- Valid drops mid-frame: the grant is held indefinitely; no timeout.
- In-flight FIFO (INFLIGHT_DEPTH entries of ID_WIDTH):
  - Push on grant; pop on chk_frame_done.
  - Push and pop in the same cycle are both honoured; occupancy is unchanged.
  - Full blocks new grants only; a frame already granted continues.
  - chk_frame_done while empty: no pop, status_frame_err is set and stays set until reset.
- Counters: on chk_frame_done & chk_bad_fcs with the FIFO not empty, increment the counter of the popped port. Counters saturate at all-ones with no wrap.
- Fairness: with all ports continuously requesting, grants rotate 0,1,2,3,0,...

Optional Feature:
ETH_FCS_SCHED_STATS_EN
- Defined: the in-flight FIFO, INFLIGHT_DEPTH limit, counters and status_frame_err are implemented as described.
- Undefined: FIFO and counters are omitted.
  - Grants are never blocked by in-flight count.
  - chk_frame_done and chk_bad_fcs are ignored.
  - status_bad_fcs_count and status_frame_err are tied to 0.
  - Arbitration and datapath timing are identical.

Test Plan:
- Reset, then port 2 sends a 3-beat frame with m_axis_tready=1 -> IDLE bubble, then 3 beats on m_axis with tid=2, s_axis_tready=3'b100 pattern only during XFER, busy high for 3 cycles.
- All 4 ports continuously valid with 1-beat frames -> tid sequence 0,1,2,3,0,1; each frame separated by exactly one idle cycle.
- Port 1 mid-frame, port 0 asserts valid -> port 0 stays tready=0 until port 1 tlast accepted; m_axis_tready toggling 1,0,1 stalls both sides with no data loss or duplication.
- With STATS_EN and 4 frames granted and no chk_frame_done -> 5th requester not granted; a single chk_frame_done pulse -> grant issued on the following cycle.
- With STATS_EN, frames from ports 0,3,3 then done pulses with bad = 0,1,1 -> count[3]=2, count[0]=0; counter preset near max by 2^CNT_WIDTH bad frames holds at 16'hFFFF.
- chk_frame_done with empty FIFO -> status_frame_err=1 and stays 1; rst_n low asynchronously mid-frame -> all tready, m_axis_tvalid, busy 0 immediately.

Source files
------------

// File: rtl/eth_fcs_check_sched_64.sv
// Frame-granular round-robin scheduler sharing one 64-bit FCS checker among PORTS AXI-Stream sources.
// Define ETH_FCS_SCHED_STATS_EN to build the in-flight tag FIFO, per-port bad-FCS counters and frame_err flag.
module eth_fcs_check_sched_64 #(
  parameter int PORTS          = 4,
  parameter int ID_WIDTH       = $clog2(PORTS),
  parameter int INFLIGHT_DEPTH = 4,
  parameter int CNT_WIDTH      = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [PORTS*64-1:0]        s_axis_tdata,
  input  logic [PORTS*8-1:0]         s_axis_tkeep,
  input  logic [PORTS-1:0]           s_axis_tvalid,
  output logic [PORTS-1:0]           s_axis_tready,
  input  logic [PORTS-1:0]           s_axis_tlast,
  input  logic [PORTS-1:0]           s_axis_tuser,
  output logic [63:0]                m_axis_tdata,
  output logic [7:0]                 m_axis_tkeep,
  output logic                       m_axis_tvalid,
  input  logic                       m_axis_tready,
  output logic                       m_axis_tlast,
  output logic                       m_axis_tuser,
  output logic [ID_WIDTH-1:0]        m_axis_tid,
  input  logic                       chk_frame_done,
  input  logic                       chk_bad_fcs,
  output logic [PORTS*CNT_WIDTH-1:0] status_bad_fcs_count,
  output logic                       status_frame_err,
  output logic                       busy
);

  typedef enum logic {IDLE, XFER} state_t;

  state_t              state_q, state_d;
  logic [ID_WIDTH-1:0] grant_q, grant_d;
  logic [ID_WIDTH-1:0] last_q, last_d;
  logic [ID_WIDTH-1:0] pick;
  logic                found;
  logic                fifo_full;
  logic                push;
  int                  idx;

  // Rotating priority: scan last_grant+1 .. last_grant+PORTS, first requester wins.
  always_comb begin
    pick  = '0;
    found = 1'b0;
    idx   = 0;
    for (int k = 1; k <= PORTS; k++) begin
      idx = int'(last_q) + k;
      if (idx >= PORTS) idx = idx - PORTS;
      if (!found && s_axis_tvalid[idx]) begin
        found = 1'b1;
        pick  = ID_WIDTH'(idx);
      end
    end
  end

  always_comb begin
    state_d       = state_q;
    grant_d       = grant_q;
    last_d        = last_q;
    push          = 1'b0;
    s_axis_tready = '0;
    m_axis_tdata  = '0;
    m_axis_tkeep  = '0;
    m_axis_tvalid = 1'b0;
    m_axis_tlast  = 1'b0;
    m_axis_tuser  = 1'b0;
    case (state_q)
      IDLE: begin
        if (found && !fifo_full) begin
          grant_d = pick;
          push    = 1'b1;
          state_d = XFER;
        end
      end
      XFER: begin
        m_axis_tdata           = s_axis_tdata[int'(grant_q)*64 +: 64];
        m_axis_tkeep           = s_axis_tkeep[int'(grant_q)*8 +: 8];
        m_axis_tvalid          = s_axis_tvalid[grant_q];
        m_axis_tlast           = s_axis_tlast[grant_q];
        m_axis_tuser           = s_axis_tuser[grant_q];
        s_axis_tready[grant_q] = m_axis_tready;
        if (s_axis_tvalid[grant_q] && m_axis_tready && s_axis_tlast[grant_q]) begin
          last_d  = grant_q;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      grant_q <= '0;
      last_q  <= ID_WIDTH'(PORTS - 1);
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
    end
  end

  assign m_axis_tid = grant_q;
  assign busy       = (state_q == XFER);

`ifdef ETH_FCS_SCHED_STATS_EN
  localparam int PTR_W = (INFLIGHT_DEPTH > 1) ? $clog2(INFLIGHT_DEPTH) : 1;

  logic [ID_WIDTH-1:0] fifo_mem [INFLIGHT_DEPTH];
  logic [PTR_W-1:0]    wr_ptr_q, rd_ptr_q;
  logic [PTR_W:0]      occ_q;
  logic                err_q;
  logic                pop;
  logic [ID_WIDTH-1:0] pop_id;

  assign fifo_full = (occ_q == (PTR_W+1)'(INFLIGHT_DEPTH));
  assign pop       = chk_frame_done && (occ_q != '0);
  assign pop_id    = fifo_mem[rd_ptr_q];

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr_q] <= pick;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
      err_q    <= 1'b0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      if (push && !pop)      occ_q <= occ_q + 1'b1;
      else if (pop && !push) occ_q <= occ_q - 1'b1;
      if (chk_frame_done && (occ_q == '0)) err_q <= 1'b1;
    end
  end

  assign status_frame_err = err_q;

  // Results arrive in grant order, so the FIFO head names the port of each done pulse.
  for (genvar gi = 0; gi < PORTS; gi++) begin : g_cnt
    logic [CNT_WIDTH-1:0] cnt_q;
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        cnt_q <= '0;
      end else if (pop && chk_bad_fcs && (pop_id == ID_WIDTH'(gi)) && (cnt_q != '1)) begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
    assign status_bad_fcs_count[gi*CNT_WIDTH +: CNT_WIDTH] = cnt_q;
  end
`else
  localparam int UNUSED_DEPTH = INFLIGHT_DEPTH;
  logic unused_chk;
  assign unused_chk           = ^{chk_frame_done, chk_bad_fcs, push};
  assign fifo_full            = 1'b0;
  assign status_frame_err     = 1'b0;
  assign status_bad_fcs_count = '0;
`endif

endmodule

// File: tb/tb_eth_fcs_check_sched_64.sv
// Scoreboard bench for eth_fcs_check_sched_64: per-port source models, beat scoreboard keyed by tid.
module tb_eth_fcs_check_sched_64;
  localparam int P  = 4;
  localparam int CW = 4;
`ifdef ETH_FCS_SCHED_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  typedef struct packed {
    logic [63:0] d;
    logic [7:0]  k;
    logic        l;
    logic        u;
  } beat_t;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [P*64-1:0] s_tdata = '0;
  logic [P*8-1:0]  s_tkeep = '0;
  logic [P-1:0]    s_tvalid = '0, s_tready, s_tlast = '0, s_tuser = '0;
  logic [63:0]     m_tdata;
  logic [7:0]      m_tkeep;
  logic            m_tvalid, m_tlast, m_tuser;
  logic            m_tready = 1'b1;
  logic [1:0]      m_tid;
  logic            auto_pulse = 1'b0, man_done = 1'b0, bad = 1'b0, auto_done = 1'b1;
  logic            chk_frame_done;
  logic [P*CW-1:0] status_cnt;
  logic            status_err, busy;

  beat_t src_q[P][$];
  beat_t exp_q[P][$];
  int    tid_log[$];
  int    cyc_log[$];
  int    vectors = 0, errors = 0, cyc = 0;
  logic [P-1:0] hs = '0;

  assign chk_frame_done = auto_pulse | man_done;

  eth_fcs_check_sched_64 #(.PORTS(P), .INFLIGHT_DEPTH(4), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst_n(rst_n),
    .s_axis_tdata(s_tdata), .s_axis_tkeep(s_tkeep), .s_axis_tvalid(s_tvalid),
    .s_axis_tready(s_tready), .s_axis_tlast(s_tlast), .s_axis_tuser(s_tuser),
    .m_axis_tdata(m_tdata), .m_axis_tkeep(m_tkeep), .m_axis_tvalid(m_tvalid),
    .m_axis_tready(m_tready), .m_axis_tlast(m_tlast), .m_axis_tuser(m_tuser),
    .m_axis_tid(m_tid), .chk_frame_done(chk_frame_done), .chk_bad_fcs(bad),
    .status_bad_fcs_count(status_cnt), .status_frame_err(status_err), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // Source models: retire the head beat after a handshake, then present the next one.
  always @(posedge clk) begin
    #1;
    for (int p = 0; p < P; p++) begin
      if (hs[p] && src_q[p].size() > 0) void'(src_q[p].pop_front());
      if (src_q[p].size() > 0) begin
        s_tvalid[p]        = 1'b1;
        s_tdata[p*64 +: 64] = src_q[p][0].d;
        s_tkeep[p*8 +: 8]   = src_q[p][0].k;
        s_tlast[p]         = src_q[p][0].l;
        s_tuser[p]         = src_q[p][0].u;
      end else begin
        s_tvalid[p] = 1'b0;
        s_tlast[p]  = 1'b0;
        s_tuser[p]  = 1'b0;
      end
    end
    hs = '0;
  end

  // Output monitor and checker model: every accepted beat must be the next expected beat of its tid.
  always @(negedge clk) begin : mon
    int    t;
    beat_t e;
    auto_pulse = 1'b0;
    hs = rst_n ? (s_tvalid & s_tready) : '0;
    if (rst_n && m_tvalid && m_tready) begin
      t = int'(m_tid);
      vectors++;
      if (exp_q[t].size() == 0) begin
        errors++;
        $display("FAIL beat_unexpected tid=%0d got data=%h required no beat", t, m_tdata);
      end else begin
        e = exp_q[t].pop_front();
        if ({m_tdata, m_tkeep, m_tlast, m_tuser} !== e) begin
          errors++;
          $display("FAIL beat_data tid=%0d got %h/%h/%b/%b required %h/%h/%b/%b",
                   t, m_tdata, m_tkeep, m_tlast, m_tuser, e.d, e.k, e.l, e.u);
        end
      end
      if (m_tlast) begin
        tid_log.push_back(t);
        cyc_log.push_back(cyc);
        $display("frame tid=%0d cyc=%0d user=%0b", t, cyc, m_tuser);
        if (auto_done) auto_pulse = 1'b1;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic send(input int p, input int n, input logic u);
    beat_t b;
    for (int i = 0; i < n; i++) begin
      b.d = {8'(p), 24'(i), $urandom};
      b.k = (i == n-1) ? 8'h3F : 8'hFF;
      b.l = (i == n-1);
      b.u = u && (i == n-1);
      src_q[p].push_back(b);
      exp_q[p].push_back(b);
    end
  endtask

  function automatic bit pending();
    for (int p = 0; p < P; p++) if (exp_q[p].size() != 0) return 1'b1;
    return 1'b0;
  endfunction

  task automatic wait_drain(input int budget);
    int i = 0;
    while (pending() && i < budget) begin
      tick();
      i++;
    end
    vectors++;
    if (i >= budget) begin
      errors++;
      $display("FAIL drain_timeout got %0d cycles required < %0d", i, budget);
    end
  endtask

  task automatic pulse_done(input logic b);
    man_done = 1'b1;
    bad      = b;
    tick();
    man_done = 1'b0;
    bad      = 1'b0;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    for (int p = 0; p < P; p++) begin
      src_q[p].delete();
      exp_q[p].delete();
    end
    tid_log.delete();
    cyc_log.delete();
    hs       = '0;
    s_tvalid = '0;
    man_done = 1'b0;
    bad      = 1'b0;
    m_tready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #1;
    vectors += 6;
    if (s_tready !== '0) begin errors++; $display("FAIL rst_tready got %b required 0000", s_tready); end
    if (m_tvalid !== 1'b0) begin errors++; $display("FAIL rst_m_tvalid got %b required 0", m_tvalid); end
    if (m_tid !== 2'd0) begin errors++; $display("FAIL rst_tid got %0d required 0", m_tid); end
    if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy got %b required 0", busy); end
    if (status_cnt !== '0) begin errors++; $display("FAIL rst_counts got %h required 0", status_cnt); end
    if (status_err !== 1'b0) begin errors++; $display("FAIL rst_frame_err got %b required 0", status_err); end
    apply_reset();
  endtask

  task automatic test_single_frame();
    int busy_cycles = 0;
    apply_reset();
    send(2, 3, 1'b1);
    for (int i = 0; i < 8; i++) begin
      tick();
      @(negedge clk);
      if (i == 0) begin
        vectors++;
        if (!(s_tvalid[2] === 1'b1 && busy === 1'b0)) begin
          errors++;
          $display("FAIL bubble got valid=%b busy=%b required valid=1 busy=0", s_tvalid[2], busy);
        end
      end
      if (busy === 1'b1) busy_cycles++;
      vectors++;
      if (s_tready !== (busy ? 4'b0100 : 4'b0000)) begin
        errors++;
        $display("FAIL single_tready cycle=%0d got %b required %b", i, s_tready, busy ? 4'b0100 : 4'b0000);
      end
    end
    vectors += 2;
    if (busy_cycles != 3) begin errors++; $display("FAIL single_busy_cycles got %0d required 3", busy_cycles); end
    if (tid_log.size() != 1 || tid_log[0] != 2) begin
      errors++;
      $display("FAIL single_tid got %0d frames required one frame tid=2", tid_log.size());
    end
    wait_drain(20);
  endtask

  task automatic test_round_robin();
    apply_reset();
    for (int r = 0; r < 2; r++)
      for (int p = 0; p < P; p++) send(p, 1, 1'b0);
    wait_drain(100);
    vectors++;
    if (tid_log.size() != 8) begin
      errors++;
      $display("FAIL rr_count got %0d required 8", tid_log.size());
    end else begin
      for (int i = 0; i < 8; i++) begin
        vectors++;
        if (tid_log[i] != i % P) begin
          errors++;
          $display("FAIL rr_order idx=%0d got %0d required %0d", i, tid_log[i], i % P);
        end
        if (i > 0) begin
          vectors++;
          if (cyc_log[i] - cyc_log[i-1] != 2) begin
            errors++;
            $display("FAIL rr_spacing idx=%0d got %0d required 2", i, cyc_log[i] - cyc_log[i-1]);
          end
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    int i = 0;
    apply_reset();
    send(1, 5, 1'b0);
    while (!(busy === 1'b1 && m_tid == 2'd1) && i < 20) begin
      tick();
      @(negedge clk);
      i++;
    end
    vectors++;
    if (i >= 20) begin errors++; $display("FAIL bp_grant_timeout got %0d cycles required < 20", i); end
    send(0, 2, 1'b1);
    for (int c = 0; c < 12; c++) begin
      tick();
      m_tready = (c % 3 != 1);
      @(negedge clk);
      if (busy === 1'b1 && m_tid == 2'd1) begin
        vectors++;
        if (s_tready !== (m_tready ? 4'b0010 : 4'b0000)) begin
          errors++;
          $display("FAIL bp_tready cycle=%0d got %b required %b", c, s_tready, m_tready ? 4'b0010 : 4'b0000);
        end
      end
    end
    m_tready = 1'b1;
    wait_drain(50);
    vectors++;
    if (tid_log.size() != 2 || tid_log[0] != 1 || tid_log[1] != 0) begin
      errors++;
      $display("FAIL bp_order got %0d frames required tids 1,0", tid_log.size());
    end
  endtask

  task automatic test_inflight_limit();
    apply_reset();
    auto_done = 1'b0;
    for (int p = 0; p < P; p++) send(p, 1, 1'b0);
    send(0, 1, 1'b0);
    repeat (20) tick();
    @(negedge clk);
    vectors++;
    if (tid_log.size() != (STATS ? 4 : 5)) begin
      errors++;
      $display("FAIL inflight_granted got %0d required %0d", tid_log.size(), STATS ? 4 : 5);
    end
    tick();
    pulse_done(1'b0);
    @(negedge clk);
    vectors++;
    if (busy !== 1'b0) begin errors++; $display("FAIL inflight_same_cycle got busy=%b required 0", busy); end
    tick();
    @(negedge clk);
    vectors += 2;
    if (busy !== STATS) begin errors++; $display("FAIL inflight_release got busy=%b required %b", busy, STATS); end
    if (m_tid !== 2'd0) begin errors++; $display("FAIL inflight_tid got %0d required 0", m_tid); end
    wait_drain(20);
    auto_done = 1'b1;
  endtask

  task automatic test_counters();
    logic [CW-1:0] got;
    int            want;
    apply_reset();
    auto_done = 1'b0;
    send(0, 1, 1'b0);
    send(3, 1, 1'b1);
    send(3, 1, 1'b1);
    wait_drain(50);
    vectors++;
    if (tid_log.size() != 3 || tid_log[0] != 0 || tid_log[1] != 3 || tid_log[2] != 3) begin
      errors++;
      $display("FAIL cnt_order got %0d frames required tids 0,3,3", tid_log.size());
    end
    pulse_done(1'b0);
    pulse_done(1'b1);
    pulse_done(1'b1);
    @(negedge clk);
    for (int p = 0; p < P; p++) begin
      got  = status_cnt[p*CW +: CW];
      want = (STATS && p == 3) ? 2 : 0;
      vectors++;
      if (got != CW'(want)) begin
        errors++;
        $display("FAIL cnt_port%0d got %0d required %0d", p, got, want);
      end
    end
    for (int i = 1; i <= (1 << CW) + 2; i++) begin
      send(1, 1, 1'b1);
      wait_drain(20);
      pulse_done(1'b1);
      @(negedge clk);
      got  = status_cnt[1*CW +: CW];
      want = STATS ? ((i > (1 << CW) - 1) ? (1 << CW) - 1 : i) : 0;
      vectors++;
      if (got != CW'(want)) begin
        errors++;
        $display("FAIL cnt_sat iter=%0d got %0d required %0d", i, got, want);
      end
    end
    auto_done = 1'b1;
  endtask

  task automatic test_frame_err_and_async_reset();
    int i = 0;
    apply_reset();
    @(negedge clk);
    vectors++;
    if (status_err !== 1'b0) begin errors++; $display("FAIL err_initial got %b required 0", status_err); end
    tick();
    pulse_done(1'b0);
    @(negedge clk);
    vectors++;
    if (status_err !== STATS) begin errors++; $display("FAIL err_set got %b required %b", status_err, STATS); end
    repeat (5) tick();
    @(negedge clk);
    vectors++;
    if (status_err !== STATS) begin errors++; $display("FAIL err_sticky got %b required %b", status_err, STATS); end
    m_tready = 1'b0;
    send(2, 4, 1'b0);
    while (busy !== 1'b1 && i < 20) begin
      tick();
      @(negedge clk);
      i++;
    end
    vectors++;
    if (i >= 20) begin errors++; $display("FAIL ar_grant_timeout got %0d cycles required < 20", i); end
    #2;
    rst_n = 1'b0;
    #1;
    vectors += 4;
    if (s_tready !== '0) begin errors++; $display("FAIL ar_tready got %b required 0000", s_tready); end
    if (m_tvalid !== 1'b0) begin errors++; $display("FAIL ar_m_tvalid got %b required 0", m_tvalid); end
    if (busy !== 1'b0) begin errors++; $display("FAIL ar_busy got %b required 0", busy); end
    if (status_err !== 1'b0) begin errors++; $display("FAIL ar_frame_err got %b required 0", status_err); end
    apply_reset();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog got no finish required finish before 2ms");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single_frame();
    test_round_robin();
    test_back_to_back();
    test_inflight_limit();
    test_counters();
    test_frame_err_and_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
